// File: rtl/leaf_user_rx_fifo.sv
// -----------------------------------------------------------------------------
// leaf_user_rx_fifo
//
// Per-port receive elastic buffer between one leaf_interface output port group
// and an HLS ap_fifo input stream. It absorbs leaf back-pressure jitter and
// presents a first-word-fall-through read side to the kernel. All logic runs
// on clk_user.
//
// Ports:
//   clk_user                  in   user clock, rising edge
//   reset                     in   synchronous, active-high
//   dout_leaf_interface2user  in   PAYLOAD_BITS  data from the leaf interface
//   vld_interface2user        in   data valid from the leaf interface
//   ack_user2interface        out  word accepted this cycle (combinational)
//   fifo_dout                 out  PAYLOAD_BITS  head word (FWFT)
//   fifo_empty_n              out  head word valid
//   fifo_read                 in   kernel consumes the head word
//   occupancy                 out  ADDR_BITS+1   words stored, 0..DEPTH
//   almost_full               out  registered occupancy >= AF_THRESH
//   word_count                out  32  words accepted since reset, wraps
//   underflow_err             out  sticky, set on read while empty
// -----------------------------------------------------------------------------
module leaf_user_rx_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_BITS    = 4,
  parameter int AF_THRESH    = 12
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] fifo_dout,
  output logic                    fifo_empty_n,
  input  logic                    fifo_read,
  output logic [ADDR_BITS:0]      occupancy,
  output logic                    almost_full,
  output logic [31:0]             word_count,
  output logic                    underflow_err
);

  localparam logic [ADDR_BITS:0] DEPTH_C = DEPTH[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] AF_C    = AF_THRESH[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] ZERO_C  = {(ADDR_BITS+1){1'b0}};

  logic [PAYLOAD_BITS-1:0] mem_r [DEPTH];
  logic [ADDR_BITS-1:0]    wr_ptr_r;
  logic [ADDR_BITS-1:0]    rd_ptr_r;
  logic [ADDR_BITS:0]      count_r;
  logic [ADDR_BITS:0]      next_count_s;
  logic [31:0]             word_count_r;
  logic                    almost_full_r;
  logic                    underflow_err_r;
  logic                    wr_en_s;
  logic                    rd_en_s;
  logic                    not_empty_s;

  assign not_empty_s = (count_r != ZERO_C);

  // Accept only when there is room; no full-bypass even if the kernel reads
  // in the same cycle. Reset masks the ack so a word offered during reset is
  // never reported as taken.
  assign wr_en_s = vld_interface2user & (count_r != DEPTH_C) & ~reset;

  // A read while empty is an underflow and does not move any state.
  assign rd_en_s = fifo_read & not_empty_s;

  assign ack_user2interface = wr_en_s;
  assign fifo_dout          = mem_r[rd_ptr_r];
  assign fifo_empty_n       = not_empty_s;
  assign occupancy          = count_r;
  assign almost_full        = almost_full_r;
  assign word_count         = word_count_r;
  assign underflow_err      = underflow_err_r;

  // Next occupancy: simultaneous read and write cancel out.
  always_comb begin
    next_count_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   next_count_s = count_r + {{ADDR_BITS{1'b0}}, 1'b1};
      2'b01:   next_count_s = count_r - {{ADDR_BITS{1'b0}}, 1'b1};
      default: next_count_s = count_r;
    endcase
  end

  // Storage array write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk_user) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= dout_leaf_interface2user;
    end
  end

  // Pointers, occupancy and status registers.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr_r        <= {ADDR_BITS{1'b0}};
      rd_ptr_r        <= {ADDR_BITS{1'b0}};
      count_r         <= ZERO_C;
      word_count_r    <= 32'd0;
      almost_full_r   <= 1'b0;
      underflow_err_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r     <= wr_ptr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
        word_count_r <= word_count_r + 32'd1;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
      end
      if (fifo_read && !not_empty_s) begin
        underflow_err_r <= 1'b1;
      end
      count_r       <= next_count_s;
      // Computed from next_count so the flag lines up with count_r.
      almost_full_r <= (next_count_s >= AF_C);
    end
  end

endmodule

// File: tb/tb_leaf_user_rx_fifo.sv
module tb_leaf_user_rx_fifo;

  logic        clk_user = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dout_leaf_interface2user = 32'd0;
  logic        vld_interface2user = 1'b0;
  logic        ack_user2interface;
  logic [31:0] fifo_dout;
  logic        fifo_empty_n;
  logic        fifo_read = 1'b0;
  logic [4:0]  occupancy;
  logic        almost_full;
  logic [31:0] word_count;
  logic        underflow_err;

  leaf_user_rx_fifo #(
    .PAYLOAD_BITS(32), .DEPTH(16), .ADDR_BITS(4), .AF_THRESH(12)
  ) dut (
    .clk_user                 (clk_user),
    .reset                    (reset),
    .dout_leaf_interface2user (dout_leaf_interface2user),
    .vld_interface2user       (vld_interface2user),
    .ack_user2interface       (ack_user2interface),
    .fifo_dout                (fifo_dout),
    .fifo_empty_n             (fifo_empty_n),
    .fifo_read                (fifo_read),
    .occupancy                (occupancy),
    .almost_full              (almost_full),
    .word_count               (word_count),
    .underflow_err            (underflow_err)
  );

  always #5 clk_user = ~clk_user;

  // Reference model: a plain queue of stored words plus counters.
  logic [31:0] q[$];
  logic [31:0] m_wc = 32'd0;
  logic        m_uf = 1'b0;
  int          errs = 0;
  int          checks = 0;
  int          total_acc = 0;
  logic        last_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r,
                       input logic rst, input bit chk_en);
    logic exp_ack;
    logic do_rd;
    vld_interface2user       = v;
    dout_leaf_interface2user = d;
    fifo_read                = r;
    reset                    = rst;
    #1;
    exp_ack = v && !rst && (q.size() != 16);
    last_ack = ack_user2interface;
    if (chk_en) begin
      chk("ack", {31'd0, ack_user2interface}, {31'd0, exp_ack});
      chk("empty_n", {31'd0, fifo_empty_n}, {31'd0, (q.size() != 0)});
      chk("occupancy", {27'd0, occupancy}, q.size());
      chk("almost_full", {31'd0, almost_full}, {31'd0, (q.size() >= 12)});
      chk("word_count", word_count, m_wc);
      chk("underflow_err", {31'd0, underflow_err}, {31'd0, m_uf});
      if (q.size() != 0) chk("fifo_dout", fifo_dout, q[0]);
    end
    @(posedge clk_user);
    if (rst) begin
      q.delete();
      m_wc = 32'd0;
      m_uf = 1'b0;
    end else begin
      do_rd = r && (q.size() != 0);
      if (r && q.size() == 0) m_uf = 1'b1;
      if (do_rd) void'(q.pop_front());
      if (exp_ack) begin
        q.push_back(d);
        m_wc = m_wc + 32'd1;
        total_acc++;
      end
    end
    @(negedge clk_user);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 40) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      guard++;
    end
    chk("drain_empty", {31'd0, fifo_empty_n}, 32'd0);
  endtask

  initial begin
    // Reset, then idle; vld held high during the second reset cycle.
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_occ", {27'd0, occupancy}, 32'd0);

    // Streaming 1..64 with read held high.
    for (int i = 1; i <= 64; i++) begin
      cycle(1'b1, i, 1'b1, 1'b0, 1'b1);
      chk("stream_occ_le1", {31'd0, (occupancy <= 5'd1)}, 32'd1);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("stream_wc", word_count, 32'd64);

    // Fill to full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, 1'b1);
    chk("full_occ", {27'd0, occupancy}, 32'd16);
    chk("full_af", {31'd0, almost_full}, 32'd1);
    cycle(1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b1);
    chk("full_ack17", {31'd0, last_ack}, 32'd0);
    cycle(1'b1, 32'hB000_0001, 1'b1, 1'b0, 1'b1);
    chk("full_rd_ack", {31'd0, last_ack}, 32'd0);
    cycle(1'b1, 32'hB000_0002, 1'b0, 1'b0, 1'b1);
    chk("full_next_ack", {31'd0, last_ack}, 32'd1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("full_end_occ", {27'd0, occupancy}, 32'd16);

    // Random interleave for pointer wrap.
    total_acc = 0;
    for (int n = 0; n < 400 && total_acc < 40; n++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0), 1'b0, 1'b1);
    end
    chk("wrap_count", {31'd0, (total_acc >= 40)}, 32'd1);
    drain();

    // Underflow with a simultaneous write.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("uf_flag", {31'd0, underflow_err}, 32'd1);
    chk("uf_dout", fifo_dout, 32'hDEAD_BEEF);
    chk("uf_occ", {27'd0, occupancy}, 32'd1);
    drain();

    // Mid-stream reset with 7 stored words.
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_occ", {27'd0, occupancy}, 32'd0);
    chk("rst_empty_n", {31'd0, fifo_empty_n}, 32'd0);
    chk("rst_wc", word_count, 32'd0);
    chk("rst_uf", {31'd0, underflow_err}, 32'd0);
    cycle(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_first_dout", fifo_dout, 32'h5555_AAAA);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
